// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary stream decoder: counts ones over a window of 2^N-1 valid
// bits and publishes the count on data_out with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; stream inputs ignored
// COUNT | accumulating ones over the current window
module sc_stream_decoder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         continuous,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic [N-1:0] data_out,
    output logic         done,
    output logic         busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Index of the final valid bit in a window (WIN-1 = 2^N-2).
    localparam logic [N-1:0] LAST_IDX = {{(N-1){1'b1}}, 1'b0};
    localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] ones_cnt;
    logic [N-1:0] ones_nxt;
    logic [N-1:0] sample_cnt;
    logic [N-1:0] sample_nxt;
    logic [N-1:0] data_nxt;
    logic [N-1:0] bit_ext;
    logic         done_nxt;
    logic         last_bit;

    assign bit_ext  = {{(N-1){1'b0}}, bit_in};
    assign last_bit = (state == COUNT) && bit_valid && (sample_cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ones_cnt   <= '0;
            sample_cnt <= '0;
            data_out   <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            ones_cnt   <= ones_nxt;
            sample_cnt <= sample_nxt;
            data_out   <= data_nxt;
            done       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ones_nxt   = ones_cnt;
        sample_nxt = sample_cnt;
        data_nxt   = data_out;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = COUNT;
                    ones_nxt   = '0;
                    sample_nxt = '0;
                end
            end
            COUNT: begin
                if (last_bit) begin
                    // Completion wins over start; start only decides whether we keep counting.
                    data_nxt   = ones_cnt + bit_ext;
                    done_nxt   = 1'b1;
                    ones_nxt   = '0;
                    sample_nxt = '0;
                    if (!continuous && !start) begin
                        state_nxt = IDLE;
                    end
                end else if (start) begin
                    ones_nxt   = '0;
                    sample_nxt = '0;
                end else if (bit_valid) begin
                    ones_nxt   = ones_cnt + bit_ext;
                    sample_nxt = sample_cnt + ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == COUNT);

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Bench for sc_stream_decoder (N=4): directed vector table, reset sequence,
// then random stimulus against a window-of-bits reference model.
module tb_sc_stream_decoder;
    localparam int N   = 4;
    localparam int WIN = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         continuous = 1'b0;
    logic         bit_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic [N-1:0] data_out;
    logic         done;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         s;
        logic         c;
        logic         b;
        logic         v;
        logic         e_done;
        logic [N-1:0] e_data;
        logic         e_busy;
    } vec_t;

    vec_t tbl[$];

    // Reference model: a window is just the list of accepted bits.
    bit m_in_win;
    int m_bits[$];
    int m_data;
    bit m_done;

    sc_stream_decoder #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .data_out   (data_out),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic s, input logic c, input logic b, input logic v,
                       input logic e_done, input int e_data, input logic e_busy);
        vec_t r;
        r.s      = s;
        r.c      = c;
        r.b      = b;
        r.v      = v;
        r.e_done = e_done;
        r.e_data = e_data[N-1:0];
        r.e_busy = e_busy;
        tbl.push_back(r);
    endtask

    task automatic model_reset();
        m_in_win = 1'b0;
        m_bits.delete();
        m_data = 0;
        m_done = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic c, input logic b, input logic v);
        m_done = 1'b0;
        if (!m_in_win) begin
            if (s) begin
                m_in_win = 1'b1;
                m_bits.delete();
            end
        end else if (v && m_bits.size() == WIN - 1) begin
            m_bits.push_back(int'(b));
            m_data = m_bits.sum();
            m_done = 1'b1;
            m_bits.delete();
            m_in_win = c || s;
        end else if (s) begin
            m_bits.delete();
        end else if (v) begin
            m_bits.push_back(int'(b));
        end
    endtask

    task automatic drive(input logic s, input logic c, input logic b, input logic v);
        start      = s;
        continuous = c;
        bit_in     = b;
        bit_valid  = v;
        @(posedge clk);
        #1;
        model_step(s, c, b, v);
    endtask

    initial begin
        int vcnt;
        int cyc;
        logic s, c, b, v;

        model_reset();
        #12;
        chk("reset_data", int'(data_out), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_busy", int'(busy), 0);
        rst = 1'b1;

        // 1: all ones, single window
        add(1, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= WIN; i++) add(0, 0, 1, 1, i == WIN, (i == WIN) ? 15 : 0, i != WIN);
        add(0, 0, 0, 0, 0, 15, 0);
        // 2: all zeros with gaps carrying bit_in=1
        add(1, 0, 0, 0, 0, 15, 1);
        vcnt = 0;
        cyc  = 0;
        while (vcnt < WIN) begin
            if (cyc % 3 == 2) begin
                add(0, 0, 1, 0, 0, 15, 1);
            end else begin
                vcnt++;
                add(0, 0, 0, 1, vcnt == WIN, (vcnt == WIN) ? 0 : 15, vcnt != WIN);
            end
            cyc++;
        end
        // 3: eight ones, then IDLE bits ignored
        add(1, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= WIN; i++) add(0, 0, i % 2, 1, i == WIN, (i == WIN) ? 8 : 0, i != WIN);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 0, 8, 0);
        // 4: abort mid-window, then three ones
        add(1, 0, 0, 0, 0, 8, 1);
        for (int i = 0; i < 7; i++) add(0, 0, 1, 1, 0, 8, 1);
        add(1, 0, 1, 1, 0, 8, 1);
        for (int i = 1; i <= WIN; i++) add(0, 0, i <= 3, 1, i == WIN, (i == WIN) ? 3 : 8, i != WIN);
        // 5: continuous, 5 ones then 10 ones
        add(1, 1, 0, 0, 0, 3, 1);
        for (int i = 1; i <= WIN; i++) add(0, 1, i <= 5, 1, i == WIN, (i == WIN) ? 5 : 3, 1);
        for (int i = 1; i <= WIN; i++) add(0, 1, i <= 10, 1, i == WIN, (i == WIN) ? 10 : 5, 1);
        // start on the completion edge: final bit belongs to the old window only
        add(1, 0, 0, 0, 0, 10, 1);
        for (int i = 0; i < WIN - 1; i++) add(0, 0, 1, 1, 0, 10, 1);
        add(1, 0, 1, 1, 1, 15, 1);
        for (int i = 1; i <= WIN; i++) add(0, 0, 0, 1, i == WIN, (i == WIN) ? 0 : 15, i != WIN);

        foreach (tbl[k]) begin
            drive(tbl[k].s, tbl[k].c, tbl[k].b, tbl[k].v);
            chk($sformatf("tbl%0d_done", k), int'(done), int'(tbl[k].e_done));
            chk($sformatf("tbl%0d_data", k), int'(data_out), int'(tbl[k].e_data));
            chk($sformatf("tbl%0d_busy", k), int'(busy), int'(tbl[k].e_busy));
        end

        // 6: asynchronous reset mid-window
        drive(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) drive(0, 0, 1, 1);
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_data", int'(data_out), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_busy", int'(busy), 0);
        model_reset();
        #3 rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 1);
            chk("post_rst_busy", int'(busy), 0);
            chk("post_rst_data", int'(data_out), 0);
        end

        // random phase against the model
        c = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) c = ~c;
            v = ($urandom_range(0, 3) != 0);
            b = $urandom_range(0, 1);
            drive(s, c, b, v);
            chk("rnd_done", int'(done), int'(m_done));
            chk("rnd_data", int'(data_out), m_data);
            chk("rnd_busy", int'(busy), int'(m_in_win));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_stream_decoder.md
Name: sc_stream_decoder

Overview:
- Stochastic-to-binary converter: counts the ones in a unipolar stochastic bitstream over a fixed window and outputs the result as an N-bit binary value.
- Inverse of the LFSR-plus-comparator stochastic number generator.
- Window length is 2^N-1 valid bits, matching the period of an N-bit maximal-length LFSR.
- A stream generated from binary value X by a full-period N-bit LFSR decodes back to X exactly.

Parameters:
N, 8, output width; window length WIN = 2^N-1 valid bits.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0)
start  input  1  begin a new window; restarts any window in progress
continuous  input  1  when 1, a new window begins automatically after each completed window
bit_in  input  1  stochastic stream bit
bit_valid  input  1  bit_in is sampled only on cycles where this is 1
data_out  output  N  ones-count of the last completed window; held until the next completion
done  output  1  one-cycle pulse; data_out is updated in the same cycle
busy  output  1  1 while a window is being accumulated

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - ones_cnt=0, sample_cnt=0.
  - data_out=0, done=0, busy=0.
  - Release is synchronous to clk; first action possible on the first edge with rst=1.
- States:
  - IDLE: busy=0. bit_valid/bit_in ignored. start=1 at an edge → COUNT, both counters cleared. The bit presented in the start cycle is NOT counted.
  - COUNT: busy=1. Each edge with bit_valid=1:
    - ones_cnt += bit_in
    - sample_cnt += 1
    - Edges with bit_valid=0 change nothing.
- Completion (the edge accepting valid bit number WIN, i.e. sample_cnt==WIN-1 and bit_valid=1):
  - data_out <= ones_cnt + bit_in (count includes the final bit).
  - done <= 1 for exactly one cycle.
  - Counters cleared.
  - continuous=1: stay in COUNT, busy stays 1, and the next valid bit is bit 1 of the new window. No bit lost or double-counted.
  - continuous=0: → IDLE, busy=0.
- start during COUNT (not at completion edge):
  - Abort; counters cleared, remain in COUNT.
  - data_out holds its previous value; no done.
  - The bit in that cycle is not counted.
- start on the completion edge:
  - Completion takes effect (data_out loaded, done pulses).
  - A new window starts; the bit is counted in the completing window only.
- Arithmetic:
  - ones_cnt is N bits; max value WIN=2^N-1, so no overflow is possible.
  - sample_cnt is N bits and never exceeds WIN-1.
  - Unsigned throughout.
- Latency: done and the new data_out are visible in the cycle after the edge that samples the final bit.
- data_out is registered and stable whenever done=0.
- Reset mid-window discards partial counts; data_out returns to 0.

Test Plan:
1. N=4 (WIN=15), continuous=0: start, then 15 cycles of bit_valid=1, bit_in=1 → done pulses once after the 15th bit, data_out=15, busy falls to 0.
2. N=4: start, 15 valid bits of all 0 with bit_valid=0 inserted every third cycle → done only after the 15th valid bit, data_out=0, gaps not counted.
3. N=4: 15 valid bits containing 8 ones, then bit_valid=1 in IDLE with bit_in=1 → data_out=8; IDLE bits ignored and data_out stays 8.
4. N=4: window 1 yields 8; start again, feed 7 valid ones, pulse start mid-window, then 15 valid bits with 3 ones → no done at the abort, data_out stays 8 until the final done, then 3.
5. N=4, continuous=1: 30 consecutive valid bits, the first 15 with 5 ones and the next 15 with 10 ones → done pulses exactly 15 cycles apart, data_out=5 then 10, busy held at 1.
6. N=4: feed 9 valid ones, assert rst=0 mid-cycle (asynchronous) → data_out=0, done=0, busy=0 immediately; after release, bits ignored until start.
